// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: FSM state encoding,
// parity mode constants and the baud divisor calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4,
        S_BRK   = 3'd5
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud-rate timer: mid-bit sample strike and end-of-bit strobe.
// Defining UART_RX_MAJORITY_EN selects 2-of-3 voting around mid-bit.
module uart_bit_timer #(
    parameter int DIV = 434
) (
    input  logic sclk,
    input  logic rst,
    input  logic restart,
    input  logic din,
    output logic sample_tick,
    output logic bit_done,
    output logic bit_val
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || (cnt == CW'(DIV - 1))) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_done = (cnt == CW'(DIV - 1));

`ifdef UART_RX_MAJORITY_EN
    // hist holds the line at counts DIV/2-1 (bit 0) and DIV/2-2 (bit 1) when
    // the vote is taken at DIV/2, so the decision lands one cycle later.
    logic [1:0] hist;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], din};
        end
    end

    assign sample_tick = (cnt == CW'(DIV / 2));
    assign bit_val     = (hist[1] & hist[0]) | (hist[1] & din) | (hist[0] & din);
`else
    assign sample_tick = (cnt == CW'(DIV / 2 - 1));
    assign bit_val     = din;
`endif

endmodule

// File: rtl/uart_rx_pack.sv
// UART receiver (configurable width/parity) packing characters into OUT_W
// words for the SDRAM write FIFO. Majority sampling: UART_RX_MAJORITY_EN.
module uart_rx_pack
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int OUT_W     = 16
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             rx,
    input  logic             flush,
    output logic [OUT_W-1:0] po_data,
    output logic             po_flag,
    output logic             frame_err,
    output logic             parity_err,
    output logic             busy,
    output logic [2:0]       state_dbg
);

    localparam int DIV  = calc_div(CLK_FREQ, BAUD);
    localparam int PACK = OUT_W / DATA_BITS;
    localparam int LW   = $clog2(PACK + 1);
    localparam int BW   = $clog2(DATA_BITS + 2);

    logic rx_meta, rx_sync, rx_prev, fall;
    logic restart, sample_tick, bit_done, bit_val;
    state_t state;
    logic [BW-1:0] bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic par_bad, ones_odd, accept, emit;
    logic [OUT_W-1:0] pack_q, pack_n;
    logic [LW-1:0] lane, lane_n;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall = rx_prev & ~rx_sync;

    // The fall cycle is count 0 of the start bit, so the timer is only held
    // while idle with no edge pending, and while waiting out a break.
    assign restart = ((state == S_IDLE) && !fall) || (state == S_BRK);

    uart_bit_timer #(
        .DIV (DIV)
    ) u_timer (
        .sclk        (sclk),
        .rst         (rst),
        .restart     (restart),
        .din         (rx_sync),
        .sample_tick (sample_tick),
        .bit_done    (bit_done),
        .bit_val     (bit_val)
    );

    assign ones_odd = (^shreg) ^ bit_val;
    assign busy     = (state != S_IDLE);
    assign state_dbg = state;

    // bit_cnt counts completed bit periods including the start bit, so the
    // sample of data bit k sees bit_cnt == k+1.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        bit_cnt <= '0;
                        par_bad <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (sample_tick) state <= bit_val ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (bit_done) bit_cnt <= bit_cnt + BW'(1);
                    if (sample_tick) begin
                        shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == BW'(DATA_BITS))
                            state <= (PARITY != PAR_NONE) ? S_PAR : S_STOP;
                    end
                end
                S_PAR: begin
                    if (sample_tick) begin
                        par_bad <= (PARITY == PAR_ODD) ? ~ones_odd : ones_odd;
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (sample_tick) begin
                        if (!bit_val) begin
                            frame_err <= 1'b1;
                            state     <= S_BRK;
                        end else begin
                            parity_err <= par_bad;
                            state      <= S_IDLE;
                        end
                    end
                end
                S_BRK: begin
                    if (rx_sync) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign accept = (state == S_STOP) && sample_tick && bit_val && !par_bad;

    // The character is merged before the flush decision, so a flush on the
    // completing accept yields exactly one strobe.
    always_comb begin
        pack_n = pack_q;
        lane_n = lane;
        if (accept) begin
            pack_n[int'(lane)*DATA_BITS +: DATA_BITS] = shreg;
            lane_n = lane + LW'(1);
        end
        emit = (lane_n == LW'(PACK)) || (flush && (lane_n != '0));
    end

    // po_flag is a one-cycle strobe with no backpressure; po_data holds its
    // last word between strobes.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            pack_q  <= '0;
            lane    <= '0;
            po_data <= '0;
            po_flag <= 1'b0;
        end else begin
            po_flag <= 1'b0;
            if (emit) begin
                po_data <= pack_n;
                po_flag <= 1'b1;
                pack_q  <= '0;
                lane    <= '0;
            end else begin
                pack_q <= pack_n;
                lane   <= lane_n;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_pack.sv
// Directed bench for uart_rx_pack: 8N1 instance (DIV 434) and 8E1 instance
// (DIV 100), checking words, error pulses, flush, breaks and timing.
module tb_uart_rx_pack;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD_A   = 115200;
    localparam int BAUD_B   = 500_000;
    localparam int DIV_A    = CLK_FREQ / BAUD_A;
    localparam int DIV_B    = CLK_FREQ / BAUD_B;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
    localparam logic [7:0] SPIKE_CHAR = 8'hF0;
`else
    localparam int MAJ = 0;
    localparam logic [7:0] SPIKE_CHAR = 8'hF8;
`endif
    // Start of frame to output pulse, as seen from the driving negedge.
    localparam int LAT_A    = DIV_A / 2 + 9 * DIV_A + 2 + MAJ;
    localparam int LAT_B    = DIV_B / 2 + 10 * DIV_B + 2 + MAJ;
    localparam int FLUSH_AT = DIV_A / 2 + 9 * DIV_A + 1 + MAJ;
    localparam int FLIP_AT  = DIV_A / 2 - 1 + 4 * DIV_A;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic rx_a = 1'b1, rx_b = 1'b1, flush_a = 1'b0, flush_b = 1'b0;
    logic [15:0] po_data_a, po_data_b;
    logic po_flag_a, po_flag_b, frame_err_a, frame_err_b;
    logic parity_err_a, parity_err_b, busy_a, busy_b;
    logic [2:0] state_dbg_a, state_dbg_b;

    uart_rx_pack #(
        .CLK_FREQ (CLK_FREQ), .BAUD (BAUD_A), .DATA_BITS (8), .PARITY (0), .OUT_W (16)
    ) dut_a (
        .sclk (clk), .rst (rst), .rx (rx_a), .flush (flush_a),
        .po_data (po_data_a), .po_flag (po_flag_a), .frame_err (frame_err_a),
        .parity_err (parity_err_a), .busy (busy_a), .state_dbg (state_dbg_a)
    );

    uart_rx_pack #(
        .CLK_FREQ (CLK_FREQ), .BAUD (BAUD_B), .DATA_BITS (8), .PARITY (2), .OUT_W (16)
    ) dut_b (
        .sclk (clk), .rst (rst), .rx (rx_b), .flush (flush_b),
        .po_data (po_data_b), .po_flag (po_flag_b), .frame_err (frame_err_b),
        .parity_err (parity_err_b), .busy (busy_b), .state_dbg (state_dbg_b)
    );

    // monitor and scoreboard state
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int flag_cnt_a = 0, frame_cnt_a = 0, par_cnt_a = 0;
    int flag_cnt_b = 0, frame_cnt_b = 0, par_cnt_b = 0;
    longint last_flag_cyc_a = 0, last_err_cyc_a = 0, last_err_cyc_b = 0;
    logic [15:0] got_q_a[$];
    logic [15:0] got_q_b[$];
    logic [15:0] exp_q[$];

    always @(negedge clk) begin
        if (po_flag_a) begin
            flag_cnt_a      <= flag_cnt_a + 1;
            last_flag_cyc_a <= cyc;
            got_q_a.push_back(po_data_a);
        end
        if (frame_err_a) begin
            frame_cnt_a    <= frame_cnt_a + 1;
            last_err_cyc_a <= cyc;
        end
        if (parity_err_a) par_cnt_a <= par_cnt_a + 1;
        if (po_flag_b) begin
            flag_cnt_b <= flag_cnt_b + 1;
            got_q_b.push_back(po_data_b);
        end
        if (frame_err_b) begin
            frame_cnt_b    <= frame_cnt_b + 1;
            last_err_cyc_b <= cyc;
        end
        if (parity_err_b) begin
            par_cnt_b      <= par_cnt_b + 1;
            last_err_cyc_b <= cyc;
        end
    end

    int checks = 0;
    int errors = 0;
    longint t0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_word(input string tag, input bit sel);
        logic [63:0] g;
        logic [15:0] e;
        e = exp_q.pop_front();
        g = 'x;
        if (!sel && got_q_a.size() > 0) g = {48'd0, got_q_a.pop_front()};
        else if (sel && got_q_b.size() > 0) g = {48'd0, got_q_b.pop_front()};
        chk(tag, g, {48'd0, e});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // driver: one frame, LSB first; optional flush strobe and single-cycle
    // line inversion at driver cycle indices; nper limits the bit periods sent
    task automatic send(input bit sel, input logic [7:0] data, input bit use_par,
                        input logic par_bit, input logic stop_bit, input int flush_at,
                        input int flip_at, input int nper, output longint start);
        logic [10:0] fr;
        logic v;
        int div;
        div = sel ? DIV_B : DIV_A;
        if (use_par) fr = {stop_bit, par_bit, data, 1'b0};
        else         fr = {1'b1, stop_bit, data, 1'b0};
        start = 0;
        for (int c = 0; c < nper * div; c++) begin
            @(negedge clk);
            if (c == 0) start = cyc;
            v = fr[c / div];
            if (c == flip_at) v = ~v;
            if (sel) rx_b = v;
            else     rx_a = v;
            flush_a = (c == flush_at);
        end
        flush_a = 1'b0;
    endtask

    initial begin
        wait_cyc(4);
        chk("rst_po_data", po_data_a, 16'h0000);
        chk("rst_po_flag", po_flag_a, 1'b0);
        chk("rst_frame_err", frame_err_a, 1'b0);
        chk("rst_parity_err", parity_err_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_state", state_dbg_a, 3'd0);
        rst = 1'b0;
        wait_cyc(5);

        // two 8N1 characters pack low lane first
        exp_q.push_back(16'h3412);
        send(0, 8'h12, 0, 1'b0, 1'b1, -1, -1, 10, t0);
        send(0, 8'h34, 0, 1'b0, 1'b1, -1, -1, 10, t0);
        wait_cyc(5);
        chk_word("word_3412", 0);
        chk("flag_cnt_pair", flag_cnt_a, 1);
        chk("flag_lat_pair", last_flag_cyc_a - t0, LAT_A);
        chk("err_cnt_pair", frame_cnt_a + par_cnt_a, 0);

        // bad stop bit followed by a 20-bit break
        send(0, 8'h41, 0, 1'b0, 1'b0, -1, -1, 10, t0);
        wait_cyc(20 * DIV_A);
        chk("busy_in_break", busy_a, 1'b1);
        chk("frame_cnt", frame_cnt_a, 1);
        chk("frame_lat", last_err_cyc_a - t0, LAT_A);
        chk("frame_no_flag", flag_cnt_a, 1);
        rx_a = 1'b1;
        wait_cyc(6);
        chk("busy_after_break", busy_a, 1'b0);
        chk("frame_no_parity", par_cnt_a, 0);

        // flush of a half-filled word
        send(0, 8'h9C, 0, 1'b0, 1'b1, -1, -1, 10, t0);
        wait_cyc(5);
        exp_q.push_back(16'h009C);
        @(negedge clk) flush_a = 1'b1;
        @(negedge clk) flush_a = 1'b0;
        chk("flush_flag", po_flag_a, 1'b1);
        chk("flush_data", po_data_a, 16'h009C);
        wait_cyc(3);
        chk_word("word_009c", 0);
        chk("flag_cnt_flush", flag_cnt_a, 2);

        // flush with nothing pending
        @(negedge clk) flush_a = 1'b1;
        @(negedge clk) flush_a = 1'b0;
        chk("flush_empty_flag", po_flag_a, 1'b0);
        wait_cyc(3);
        chk("flag_cnt_flush_empty", flag_cnt_a, 2);

        // flush on the accept that completes a word: single strobe
        exp_q.push_back(16'h2211);
        send(0, 8'h11, 0, 1'b0, 1'b1, -1, -1, 10, t0);
        send(0, 8'h22, 0, 1'b0, 1'b1, FLUSH_AT, -1, 10, t0);
        wait_cyc(5);
        chk_word("word_2211", 0);
        chk("flag_cnt_full_flush", flag_cnt_a, 3);
        chk("flag_lat_full_flush", last_flag_cyc_a - t0, LAT_A);

        // flush on the first accept: partial word including that character
        exp_q.push_back(16'h005A);
        send(0, 8'h5A, 0, 1'b0, 1'b1, FLUSH_AT, -1, 10, t0);
        wait_cyc(5);
        chk_word("word_005a", 0);
        chk("flag_cnt_part_flush", flag_cnt_a, 4);
        chk("flag_lat_part_flush", last_flag_cyc_a - t0, LAT_A);

        // 0.3-bit glitch is a false start
        @(negedge clk) rx_a = 1'b0;
        wait_cyc(DIV_A * 3 / 10);
        rx_a = 1'b1;
        chk("glitch_busy", busy_a, 1'b1);
        wait_cyc(DIV_A);
        chk("glitch_idle", busy_a, 1'b0);
        chk("glitch_outputs", {flag_cnt_a, frame_cnt_a, par_cnt_a}, {32'd4, 32'd1, 32'd0});

        // reset mid-character drops both the character and a pending lane
        send(0, 8'h77, 0, 1'b0, 1'b1, -1, -1, 10, t0);
        send(0, 8'hEE, 0, 1'b0, 1'b1, -1, -1, 4, t0);
        chk("busy_mid_data", busy_a, 1'b1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_po_data", po_data_a, 16'h0000);
        chk("rst_mid_po_flag", po_flag_a, 1'b0);
        chk("rst_mid_busy", busy_a, 1'b0);
        chk("rst_mid_frame_err", frame_err_a, 1'b0);
        rx_a = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(5);

        // clean pair; bit 3 of 0xF0 gets a one-cycle spike at its sample point
        exp_q.push_back({8'h0F, SPIKE_CHAR});
        send(0, 8'hF0, 0, 1'b0, 1'b1, -1, FLIP_AT, 10, t0);
        send(0, 8'h0F, 0, 1'b0, 1'b1, -1, -1, 10, t0);
        wait_cyc(5);
        chk_word("word_after_rst", 0);
        chk("flag_cnt_after_rst", flag_cnt_a, 5);

        // even parity: 0x07 needs parity 1, 0 is sent
        exp_q.push_back(16'h55AA);
        send(1, 8'h07, 1, 1'b0, 1'b1, -1, -1, 11, t0);
        wait_cyc(5);
        chk("par_err_cnt", par_cnt_b, 1);
        chk("par_err_lat", last_err_cyc_b - t0, LAT_B);
        chk("par_err_no_flag", flag_cnt_b, 0);
        send(1, 8'hAA, 1, 1'b0, 1'b1, -1, -1, 11, t0);
        send(1, 8'h55, 1, 1'b0, 1'b1, -1, -1, 11, t0);
        wait_cyc(5);
        chk_word("word_55aa", 1);
        chk("flag_cnt_b", flag_cnt_b, 1);
        chk("par_cnt_b_after", par_cnt_b, 1);

        // bad parity and bad stop together: only frame_err
        send(1, 8'h01, 1, 1'b0, 1'b0, -1, -1, 11, t0);
        wait_cyc(2 * DIV_B);
        chk("frame_b_cnt", frame_cnt_b, 1);
        chk("frame_b_lat", last_err_cyc_b - t0, LAT_B);
        chk("frame_b_no_parity", par_cnt_b, 1);
        rx_b = 1'b1;
        wait_cyc(6);
        chk("busy_b_idle", busy_b, 1'b0);
        chk("no_extra_words", got_q_a.size() + got_q_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_pack.md
# uart_rx_pack

Parametrised UART receiver and word packer; successor to the fixed 8N1 `uart_rx` feeding the SDRAM write FIFO. It adds configurable baud, character width, parity, error reporting and packing of characters into SDRAM-width words. It sits between the board `rx` pin and `wfifo_en`/`wfifo_data` of `sdram_main_ctrl`, running on `sclk`.

## Interface
- `CLK_FREQ`, 50_000_000: `sclk` frequency in Hz.
- `BAUD`, 9600: line rate. `DIV = CLK_FREQ/BAUD` (integer division).
- `DATA_BITS`, 8: character width, 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `OUT_W`, 16: output word width. Must be a multiple of `DATA_BITS`. `PACK = OUT_W/DATA_BITS`.

Ports:
- `sclk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx` in 1: asynchronous serial input, idle high.
- `flush` in 1: emit a partially filled word.
- `po_data` out OUT_W: packed word; valid while `po_flag` is high.
- `po_flag` out 1: one-cycle word-valid strobe.
- `frame_err` out 1: one-cycle pulse on a bad stop bit.
- `parity_err` out 1: one-cycle pulse on a parity mismatch.
- `busy` out 1: high in any state except IDLE.

## Operation
- `rx` passes through a 2-FF synchroniser (reset to 1). A falling edge is detected on the synchronised signal.
- FSM states: IDLE, START, DATA, PAR, STOP, BRK.
  - IDLE: on a falling edge, clear the bit counter and go to START.
  - START: at count `DIV/2-1`, if the sample is 0 go to DATA; otherwise it is a false start, so return to IDLE. No error is flagged.
  - DATA: one sample every `DIV` cycles, LSB first, `DATA_BITS` samples. Then go to PAR if `PARITY!=0`, else to STOP.
  - PAR: sample one bit. Odd parity means data bits plus parity bit contain an odd number of ones; even is the converse.
  - STOP: sample one bit.
    - Sample = 1 and parity OK: the character is accepted into the packer; go to IDLE.
    - Sample = 1 and parity bad: pulse `parity_err`, discard the character, go to IDLE.
    - Sample = 0: pulse `frame_err`, discard the character, go to BRK. If parity was also bad, only `frame_err` pulses.
  - BRK: wait until synchronised `rx`=1, then go to IDLE. This handles line breaks.
- IDLE is re-entered at mid-stop-bit, so back-to-back characters resynchronise on the next start edge.
- Packer:
  - The lane counter `lane` runs 0..PACK-1.
  - The k-th accepted character is written to bits `[k*DATA_BITS +: DATA_BITS]`.
  - When `lane` reaches PACK, `po_data` is loaded, `po_flag` pulses, and the lanes and `lane` clear.
- Flush:
  - If `flush` is high and `lane>0`: emit the partial word with unfilled lanes zero, pulse `po_flag`, clear.
  - If `flush` is high and `lane==0`: no effect.
- Flush coinciding with a character accept: the character is added first. If that completes the word, emit normally and the flush is consumed with no second strobe. Otherwise emit the partial word including the new character.
- Errored characters never touch the packer state.

## Timing
- Reset values: `po_data`=0, `po_flag`=0, `frame_err`=0, `parity_err`=0, `busy`=0, state IDLE, `lane`=0, synchroniser=1. An asserted `rst` mid-character abandons the character and any partial word.
- Sample points are at `DIV/2-1 + n*DIV` cycles after the synchronised falling edge.
- Total synchroniser latency is 2 cycles.
- `po_flag`, `frame_err` and `parity_err` are registered. Each asserts exactly 1 cycle after the stop-bit sample cycle (or after the `flush` cycle) for one cycle.
- Minimum spacing between `po_flag` pulses is one character time; there is no backpressure. The downstream FIFO must accept every strobe.
- The baud counter width is `$clog2(DIV)`. The counter wraps to 0 at `DIV-1`.

## Configuration
- `UART_RX_MAJORITY_EN`:
  - Defined: each bit value is the 2-of-3 majority of samples at counts `DIV/2-2`, `DIV/2-1` and `DIV/2`. The decision cycle remains `DIV/2-1`+1, i.e. one cycle later than without the macro. All output latencies shift by +1.
  - Undefined: single sample at `DIV/2-1`.

## Structure
- Shared package `uart_pkg`:
  - State enum (IDLE, START, DATA, PAR, STOP, BRK).
  - Parity constants `PAR_NONE`=0, `PAR_ODD`=1, `PAR_EVEN`=2.
  - A function computing `DIV`.
- One sub-module, `uart_bit_timer`:
  - Parameter DIV.
  - Input `restart`.
  - Outputs `sample_tick` (mid-bit) and `bit_done`.
  - The FSM and packer remain in `uart_rx_pack`.

## Test plan
- 8N1 at CLK_FREQ=50e6, BAUD=115200 (DIV=434): send 0x12 then 0x34 → one `po_flag` with `po_data`=16'h3412; `frame_err`=`parity_err`=0.
- PARITY=2: send 0x07 with parity bit 0 (wrong) → `parity_err` pulse. Then send 0xAA, 0x55 with correct parity → `po_data`=16'h55AA.
- Stop bit forced 0 on 0x41, `rx` held low for 20 bit times → one `frame_err`, `busy` high until `rx` returns high, no `po_flag`.
- Send 0x9C, then assert `flush` → `po_data`=16'h009C. `flush` with `lane`=0 → no strobe. `flush` in the same cycle as the second character's accept → a single strobe carrying the full word.
- A 0.3-bit-wide low glitch on idle `rx` → false start, no outputs. `rst` asserted mid-DATA → all outputs 0 next cycle; the next clean pair packs correctly.
- With `UART_RX_MAJORITY_EN`: a 1-cycle inverted spike at the centre of bit 3 of 0xF0 → received 0xF0 unchanged.
